hazard_stall_ctrl: RTL and testbench

// - Produces hazard_detected for the ID-stage control decoder, plus pc_write and ifid_write for the PC and IF/ID registers.
// - Detects load-use and branch-operand hazards for ID-resolved BEQ.
// - A small FSM holds multi-cycle stalls; a saturating counter tracks total stall cycles for performance monitoring.
// - Sits between the ID/EX and EX/MEM pipeline registers and the ID-stage decoder.

---
 rtl/mips_pkg.sv | 22 ++
 rtl/sat_counter.sv | 25 ++
 rtl/hazard_stall_ctrl.sv | 123 ++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: opcode constants, hazard FSM state
// encoding and a helper that says whether an opcode reads its rt field.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;

   typedef enum logic [0:0] {
      ST_RUN   = 1'b0,
      ST_STALL = 1'b1
   } state_t;

   // Only R-type, SW and BEQ read rt as a source. LW/ADDI write rt, and any
   // unknown opcode is treated as reading rs alone.
   function automatic logic op_uses_rt(input logic [5:0] opcode);
      return (opcode == OP_RTYPE) || (opcode == OP_SW) || (opcode == OP_BEQ);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments once per clock while inc is high and
// sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   logic at_max;

   assign at_max = (count == {CNT_W{1'b1}});

   // Count up on inc, hold at the ceiling.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (inc && !at_max) begin
         count <= count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// ID-stage hazard unit for a MIPS pipeline with BEQ resolved in ID.
// Detects load-use and branch-operand hazards, drives the bubble/hold
// controls, and counts stalled cycles for performance monitoring.
//
// Hold semantics: whenever hazard_detected is high, the decoder emits a
// bubble and pc_write/ifid_write are low in that same cycle, so the PC and
// IF/ID registers keep their contents on that clock edge. There is no
// handshake; the three outputs are strictly complementary at all times.
module hazard_stall_ctrl
   import mips_pkg::*;
#(
   parameter int REG_W = 5,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [5:0]       id_opcode,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             ex_mem_read,
   input  logic             ex_reg_write,
   input  logic [REG_W-1:0] ex_dest,
   input  logic             mem_mem_read,
   input  logic [REG_W-1:0] mem_dest,
   output logic             hazard_detected,
   output logic             pc_write,
   output logic             ifid_write,
   output logic [CNT_W-1:0] stall_cycles
);

   state_t     state;
   state_t     state_next;
   logic [1:0] rem;
   logic [1:0] rem_next;

   logic       uses_rt;
   logic       is_beq;
   logic       match_ex;
   logic       match_mem;
   logic [1:0] n_req;
   logic       hazard_fsm;

   // Source-operand matching against the EX and MEM destinations.
   // Register $zero is never a real producer, so it never matches.
   always_comb begin
      uses_rt   = op_uses_rt(id_opcode);
      is_beq    = (id_opcode == OP_BEQ);
      match_ex  = (ex_dest != '0) &&
                  ((ex_dest == id_rs) || (uses_rt && (ex_dest == id_rt)));
      match_mem = (mem_dest != '0) &&
                  ((mem_dest == id_rs) || (uses_rt && (mem_dest == id_rt)));
   end

   // Required stall length: a load feeding BEQ needs two bubbles (the load
   // result exists only after MEM), other hazards need one. Largest wins.
   always_comb begin
      n_req = 2'd0;
      if (ex_mem_read && match_ex) begin
         n_req = is_beq ? 2'd2 : 2'd1;
      end else if (is_beq && ex_reg_write && !ex_mem_read && match_ex) begin
         n_req = 2'd1;
      end else if (is_beq && mem_mem_read && match_mem) begin
         n_req = 2'd1;
      end
   end

   // State and remaining-stall registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_RUN;
         rem   <= 2'd0;
      end else begin
         state <= state_next;
         rem   <= rem_next;
      end
   end

   // Next-state and raw stall request. RUN reacts in the same cycle (Mealy);
   // a one-cycle stall simply re-evaluates in RUN, and only the two-cycle
   // case parks in STALL, where the inputs are ignored.
   always_comb begin
      state_next = state;
      rem_next   = rem;
      hazard_fsm = 1'b0;
      unique case (state)
         ST_RUN: begin
            if (n_req != 2'd0) begin
               hazard_fsm = 1'b1;
            end
            if (n_req == 2'd2) begin
               state_next = ST_STALL;
               rem_next   = 2'd1;
            end
         end
         ST_STALL: begin
            hazard_fsm = 1'b1;
            rem_next   = (rem == 2'd0) ? 2'd0 : rem - 2'd1;
            if (rem <= 2'd1) begin
               state_next = ST_RUN;
            end
         end
         default: begin
            state_next = ST_RUN;
            rem_next   = 2'd0;
         end
      endcase
   end

   // While reset is held the pipeline must run freely whatever the inputs.
   assign hazard_detected = rst_n & hazard_fsm;
   assign pc_write        = ~hazard_detected;
   assign ifid_write      = ~hazard_detected;

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (hazard_detected),
      .count (stall_cycles)
   );

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed scenarios plus randomized traffic
// against a behavioural model, and a narrow-counter instance for saturation.
module tb_hazard_stall_ctrl;
   import mips_pkg::*;

   localparam int REG_W = 5;
   localparam int CNT_W = 32;
   localparam longint unsigned CNT_MAX = 64'hFFFF_FFFF;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst_n;
   logic [5:0]       id_opcode;
   logic [REG_W-1:0] id_rs, id_rt, ex_dest, mem_dest;
   logic             ex_mem_read, ex_reg_write, mem_mem_read;
   logic             hazard_detected, pc_write, ifid_write;
   logic [CNT_W-1:0] stall_cycles;

   hazard_stall_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .id_opcode       (id_opcode),
      .id_rs           (id_rs),
      .id_rt           (id_rt),
      .ex_mem_read     (ex_mem_read),
      .ex_reg_write    (ex_reg_write),
      .ex_dest         (ex_dest),
      .mem_mem_read    (mem_mem_read),
      .mem_dest        (mem_dest),
      .hazard_detected (hazard_detected),
      .pc_write        (pc_write),
      .ifid_write      (ifid_write),
      .stall_cycles    (stall_cycles)
   );

   // Narrow-counter instance, held on a constant load-use hazard.
   logic       s_rst_n;
   logic       s_hazard, s_pc_write, s_ifid_write;
   logic [3:0] s_cycles;
   logic [5:0] s_opcode = OP_RTYPE;
   logic [REG_W-1:0] s_rs = 5'd8, s_rt = 5'd1, s_ex_dest = 5'd8, s_mem_dest = 5'd0;

   hazard_stall_ctrl #(.REG_W(REG_W), .CNT_W(4)) dut_sat (
      .clk             (clk),
      .rst_n           (s_rst_n),
      .id_opcode       (s_opcode),
      .id_rs           (s_rs),
      .id_rt           (s_rt),
      .ex_mem_read     (1'b1),
      .ex_reg_write    (1'b1),
      .ex_dest         (s_ex_dest),
      .mem_mem_read    (1'b0),
      .mem_dest        (s_mem_dest),
      .hazard_detected (s_hazard),
      .pc_write        (s_pc_write),
      .ifid_write      (s_ifid_write),
      .stall_cycles    (s_cycles)
   );

   // ---------------- scoreboard ----------------
   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // forced: cycles still owed after a two-cycle stall was started.
   int              forced = 0;
   longint unsigned m_cnt  = 0;

   function automatic bit hits(input logic [REG_W-1:0] dest, input bit rt_src);
      if (dest == 0) return 1'b0;
      return (dest == id_rs) || (rt_src && dest == id_rt);
   endfunction

   function automatic int req_n();
      bit rt_src;
      bit beq;
      int n;
      rt_src = (id_opcode == OP_RTYPE) || (id_opcode == OP_SW) || (id_opcode == OP_BEQ);
      beq    = (id_opcode == OP_BEQ);
      n      = 0;
      if (ex_mem_read && hits(ex_dest, rt_src))                    n = beq ? 2 : 1;
      if (beq && ex_reg_write && !ex_mem_read && hits(ex_dest, rt_src) && n < 1) n = 1;
      if (beq && mem_mem_read && hits(mem_dest, rt_src) && n < 1)  n = 1;
      return n;
   endfunction

   // Compare outputs with the model, then advance the model across the
   // coming rising edge.
   task automatic check_now(input string tag);
      int n;
      bit eh;
      n  = req_n();
      eh = (forced > 0) || (n > 0);
      check({tag, "_hz"},   hazard_detected, eh);
      check({tag, "_pcw"},  pc_write, !eh);
      check({tag, "_ifw"},  ifid_write, !eh);
      check({tag, "_cnt"},  stall_cycles, m_cnt);
      if (eh && m_cnt < CNT_MAX) m_cnt++;
      if (forced > 0) forced--;
      else if (n == 2) forced = 1;
   endtask

   // ---------------- driver tasks ----------------
   task automatic set_in(input logic [5:0] op, input int rs, input int rt,
                         input bit emr, input bit erw, input int ed,
                         input bit mmr, input int md);
      id_opcode    = op;
      id_rs        = REG_W'(rs);
      id_rt        = REG_W'(rt);
      ex_mem_read  = emr;
      ex_reg_write = erw;
      ex_dest      = REG_W'(ed);
      mem_mem_read = mmr;
      mem_dest     = REG_W'(md);
   endtask

   task automatic drive(input string tag, input logic [5:0] op, input int rs, input int rt,
                        input bit emr, input bit erw, input int ed,
                        input bit mmr, input int md);
      @(negedge clk);
      set_in(op, rs, rt, emr, erw, ed, mmr, md);
      #1;
      check_now(tag);
   endtask

   task automatic bubble(input string tag);
      drive(tag, OP_ADDI, 0, 0, 1'b0, 1'b0, 0, 1'b0, 0);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      set_in(OP_ADDI, 0, 0, 1'b0, 1'b0, 0, 1'b0, 0);
      forced = 0;
      m_cnt  = 0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   logic [5:0] op_tab [6];

   initial begin
      op_tab[0] = OP_RTYPE; op_tab[1] = OP_LW;  op_tab[2] = OP_SW;
      op_tab[3] = OP_ADDI;  op_tab[4] = OP_BEQ; op_tab[5] = 6'b111111;

      rst_n   = 1'b0;
      s_rst_n = 1'b0;
      set_in(OP_LW, 8, 8, 1'b1, 1'b1, 8, 1'b1, 8);

      // Reset state, with hazardous inputs present.
      #3;
      check("rst_hz",  hazard_detected, 1'b0);
      check("rst_pcw", pc_write, 1'b1);
      check("rst_ifw", ifid_write, 1'b1);
      check("rst_cnt", stall_cycles, 0);
      apply_reset();

      // Load-use: one stall cycle.
      drive("ld_use", OP_RTYPE, 1, 8, 1'b1, 1'b1, 8, 1'b0, 0);
      check("ld_use_hz1", hazard_detected, 1'b1);
      check("ld_use_pcw0", pc_write, 1'b0);
      bubble("ld_use_after");
      check("ld_use_hz0", hazard_detected, 1'b0);
      check("ld_use_cnt1", stall_cycles, 1);

      // Load -> BEQ: two stall cycles; the second ignores its inputs.
      apply_reset();
      drive("ld_beq1", OP_BEQ, 9, 2, 1'b1, 1'b1, 9, 1'b0, 0);
      check("ld_beq_hz_a", hazard_detected, 1'b1);
      bubble("ld_beq2");
      check("ld_beq_hz_b", hazard_detected, 1'b1);
      bubble("ld_beq3");
      check("ld_beq_run", hazard_detected, 1'b0);
      check("ld_beq_cnt2", stall_cycles, 2);

      // ALU -> BEQ on rt: one stall; $zero destination never stalls.
      apply_reset();
      drive("alu_beq", OP_BEQ, 3, 10, 1'b0, 1'b1, 10, 1'b0, 0);
      check("alu_beq_hz", hazard_detected, 1'b1);
      bubble("alu_beq_after");
      check("alu_beq_cnt1", stall_cycles, 1);
      drive("alu_beq_zero", OP_BEQ, 0, 0, 1'b0, 1'b1, 0, 1'b0, 0);
      check("alu_beq_zero_hz", hazard_detected, 1'b0);

      // LW reads only rs: rt match is not a hazard.
      drive("lw_rt", OP_LW, 4, 8, 1'b1, 1'b1, 8, 1'b0, 0);
      check("lw_rt_hz", hazard_detected, 1'b0);

      // Load in MEM feeding BEQ: one stall.
      drive("mem_beq", OP_BEQ, 6, 7, 1'b0, 1'b0, 0, 1'b1, 7);
      check("mem_beq_hz", hazard_detected, 1'b1);

      // Reset during the STALL-state cycle of a load -> BEQ stall.
      apply_reset();
      drive("rs_pre1", OP_RTYPE, 8, 0, 1'b1, 1'b1, 8, 1'b0, 0);
      drive("rs_pre2", OP_BEQ, 9, 1, 1'b1, 1'b1, 9, 1'b0, 0);
      bubble("rs_stall");
      check("rs_stall_hz", hazard_detected, 1'b1);
      #1 rst_n = 1'b0;
      set_in(OP_RTYPE, 8, 0, 1'b1, 1'b1, 8, 1'b0, 0);
      #1;
      check("rs_mid_hz",  hazard_detected, 1'b0);
      check("rs_mid_pcw", pc_write, 1'b1);
      check("rs_mid_ifw", ifid_write, 1'b1);
      check("rs_mid_cnt", stall_cycles, 0);
      forced = 0;
      m_cnt  = 0;
      @(posedge clk);
      #1;
      check("rs_hold_hz",  hazard_detected, 1'b0);
      check("rs_hold_cnt", stall_cycles, 0);
      @(negedge clk);
      rst_n = 1'b1;
      set_in(OP_ADDI, 0, 0, 1'b0, 1'b0, 0, 1'b0, 0);
      #1;
      check_now("rs_rel");
      check("rs_rel_run", hazard_detected, 1'b0);

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         drive("rnd", op_tab[$urandom_range(0, 5)],
               $urandom_range(0, 3), $urandom_range(0, 3),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
               1'($urandom_range(0, 1)), $urandom_range(0, 3));
      end

      // Saturation on the 4-bit counter: constant load-use hazard.
      @(negedge clk);
      s_rst_n = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         check("sat_hz", s_hazard, 1'b1);
         check("sat_cnt", s_cycles, (k > 15) ? 15 : k);
      end
      check("sat_final", s_cycles, 4'hF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
